// File: rtl/io_pkg.sv
// Shared definitions for the board input conditioning block: channel
// state encoding and the number of switch and button channels.
package io_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CHECK = 1'b1
  } chanState_t;

  localparam int SW_BITS  = 18;
  localparam int BTN_BITS = 4;

endpackage

// File: rtl/debounce_bit.sv
// One input channel: 2-flop synchronizer, optional inversion, and an
// IDLE/CHECK debounce FSM that only flips the stable bit after a full run.
module debounce_bit
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter bit INVERT          = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic stable_o,
  output logic rise_o
);

  localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic          r_sync1;
  logic          r_sync2;
  chanState_t    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_stable;
  logic          r_rise;

  chanState_t    w_nextState;
  logic [CW-1:0] w_nextCnt;
  logic          w_level;
  logic          w_toggle;

  // Synchronizers reset to the "released" level so reset looks like no input.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sync1 <= INVERT;
      r_sync2 <= INVERT;
    end else begin
      r_sync1 <= raw_i;
      r_sync2 <= r_sync1;
    end
  end

  assign w_level = r_sync2 ^ INVERT;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_stable <= 1'b0;
      r_rise   <= 1'b0;
    end else begin
      r_state  <= w_nextState;
      r_cnt    <= w_nextCnt;
      r_stable <= r_stable ^ w_toggle;
      r_rise   <= w_toggle & ~r_stable;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_level != r_stable) begin
          w_nextState = CHECK;
          w_nextCnt   = CNT_ONE;
        end else begin
          w_nextCnt   = '0;
        end
      end
      CHECK: begin
        // Counter never passes CNT_MAX: that cycle leaves CHECK instead.
        if (w_level == r_stable || r_cnt == CNT_MAX) begin
          w_nextState = IDLE;
          w_nextCnt   = '0;
        end else begin
          w_nextCnt   = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_nextState = IDLE;
        w_nextCnt   = '0;
      end
    endcase
  end

  always_comb begin
    w_toggle = 1'b0;
    if (r_state == CHECK && w_level != r_stable && r_cnt == CNT_MAX)
      w_toggle = 1'b1;
  end

  assign stable_o = r_stable;
  assign rise_o   = r_rise;

endmodule

// File: rtl/io_input_cond.sv
// Debounces the board switches and active-low push-buttons into 32-bit
// active-high words for the load/store unit, plus per-button press pulses.
module io_input_cond
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [SW_BITS-1:0]  sw_raw_i,
  input  logic [BTN_BITS-1:0] btn_n_raw_i,
  output logic [31:0]         io_sw_o,
  output logic [31:0]         io_btn_o,
  output logic [BTN_BITS-1:0] btn_press_o
);

  logic [SW_BITS-1:0]  w_swStable;
  logic [SW_BITS-1:0]  w_swRise;
  logic [BTN_BITS-1:0] w_btnStable;
  logic [BTN_BITS-1:0] w_btnRise;
  logic                w_unusedSwRise;

  for (genvar gi = 0; gi < SW_BITS; gi++) begin : g_sw
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .INVERT         (1'b0)
    ) u_deb (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .raw_i   (sw_raw_i[gi]),
      .stable_o(w_swStable[gi]),
      .rise_o  (w_swRise[gi])
    );
  end

  // Buttons are active-low on the board; inversion happens after the synchronizer.
  for (genvar gi = 0; gi < BTN_BITS; gi++) begin : g_btn
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .INVERT         (1'b1)
    ) u_deb (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .raw_i   (btn_n_raw_i[gi]),
      .stable_o(w_btnStable[gi]),
      .rise_o  (w_btnRise[gi])
    );
  end

  assign w_unusedSwRise = ^w_swRise;

  assign io_sw_o     = {{(32 - SW_BITS){1'b0}}, w_swStable};
  assign io_btn_o    = {{(32 - BTN_BITS){1'b0}}, w_btnStable};
  assign btn_press_o = w_btnRise;

endmodule

// File: tb/tb_io_input_cond.sv
// Scoreboard bench for io_input_cond with DEBOUNCE_CYCLES = 4: stimulus pushes
// hand-derived per-edge expectations, a monitor pops and compares after each edge.
module tb_io_input_cond;

  localparam int LAT = 6;

  typedef struct {
    logic [31:0] sw;
    logic [31:0] btn;
    logic [3:0]  press;
    string       name;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [17:0] swRaw;
  logic [3:0]  btnNRaw;
  logic [31:0] ioSw;
  logic [31:0] ioBtn;
  logic [3:0]  btnPress;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  io_input_cond #(.DEBOUNCE_CYCLES(4)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .sw_raw_i   (swRaw),
    .btn_n_raw_i(btnNRaw),
    .io_sw_o    (ioSw),
    .io_btn_o   (ioBtn),
    .btn_press_o(btnPress)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input exp_t e);
    total++;
    if (ioSw !== e.sw || ioBtn !== e.btn || btnPress !== e.press) begin
      bad++;
      $display("[TB] FAIL %s: got sw=%h btn=%h press=%b, expected sw=%h btn=%h press=%b",
               e.name, ioSw, ioBtn, btnPress, e.sw, e.btn, e.press);
    end
  endtask

  function automatic exp_t mkExp(input string name, input logic [17:0] sw,
                                 input logic [3:0] btn, input logic [3:0] press);
    exp_t e;
    e.sw    = {14'b0, sw};
    e.btn   = {28'b0, btn};
    e.press = press;
    e.name  = name;
    return e;
  endfunction

  // Monitor: compares one queued expectation shortly after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checkOutput(e);
      end
    end
  end

  task automatic applyStimulus(input logic [17:0] sw, input logic [3:0] btnN);
    @(negedge clk);
    swRaw   = sw;
    btnNRaw = btnN;
  endtask

  task automatic runEdge(input string name, input logic [17:0] sw,
                         input logic [3:0] btn, input logic [3:0] press);
    @(posedge clk);
    q.push_back(mkExp(name, sw, btn, press));
  endtask

  // Edge k after an input change: old value until LAT-1, new from LAT on.
  task automatic holdCheck(input string name,
                           input logic [17:0] oldSw, input logic [17:0] newSw,
                           input logic [3:0] oldBtn, input logic [3:0] newBtn,
                           input logic [3:0] pressMask, input int n);
    for (int k = 1; k <= n; k++)
      runEdge($sformatf("%s_e%0d", name, k),
              (k < LAT) ? oldSw : newSw,
              (k < LAT) ? oldBtn : newBtn,
              (k == LAT) ? pressMask : 4'h0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, queue=%0d", q.size());
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst     = 1'b1;
    swRaw   = '0;
    btnNRaw = 4'hF;
    #1;
    checkOutput(mkExp("reset_async", 18'h0, 4'h0, 4'h0));
    repeat (3) runEdge("reset_hold", 18'h0, 4'h0, 4'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) runEdge("idle", 18'h0, 4'h0, 4'h0);

    // Single switch rise and fall with full latency
    applyStimulus(18'h00001, 4'hF);
    holdCheck("sw0_rise", 18'h0, 18'h1, 4'h0, 4'h0, 4'h0, 10);
    applyStimulus(18'h00000, 4'hF);
    holdCheck("sw0_fall", 18'h1, 18'h0, 4'h0, 4'h0, 4'h0, 10);

    // Three-cycle button glitch must be rejected
    applyStimulus(18'h0, 4'b1011);
    repeat (3) runEdge("btn2_glitch", 18'h0, 4'h0, 4'h0);
    applyStimulus(18'h0, 4'hF);
    repeat (8) runEdge("btn2_after", 18'h0, 4'h0, 4'h0);

    // Button 0 press with one pulse, release without pulse
    applyStimulus(18'h0, 4'b1110);
    holdCheck("btn0_press", 18'h0, 18'h0, 4'h0, 4'h1, 4'h1, 10);
    applyStimulus(18'h0, 4'hF);
    holdCheck("btn0_release", 18'h0, 18'h0, 4'h1, 4'h0, 4'h0, 10);

    // Switch 5 bounces 0,1,0,1 then holds
    applyStimulus(18'h00020, 4'hF);
    runEdge("sw5_b1", 18'h0, 4'h0, 4'h0);
    applyStimulus(18'h00000, 4'hF);
    runEdge("sw5_b2", 18'h0, 4'h0, 4'h0);
    applyStimulus(18'h00020, 4'hF);
    holdCheck("sw5_hold", 18'h0, 18'h20, 4'h0, 4'h0, 4'h0, 10);
    applyStimulus(18'h00000, 4'hF);
    holdCheck("sw5_clear", 18'h20, 18'h0, 4'h0, 4'h0, 4'h0, 10);

    // Async reset while btn0 is mid-CHECK, with switches already stable high
    applyStimulus(18'h00003, 4'hF);
    holdCheck("sw01_set", 18'h0, 18'h3, 4'h0, 4'h0, 4'h0, 10);
    applyStimulus(18'h00003, 4'b1110);
    repeat (4) runEdge("btn0_check", 18'h3, 4'h0, 4'h0);
    #3;
    rst = 1'b1;
    #1;
    checkOutput(mkExp("reset_midcheck", 18'h0, 4'h0, 4'h0));
    repeat (2) runEdge("reset_mid_hold", 18'h0, 4'h0, 4'h0);
    @(negedge clk);
    rst = 1'b0;
    holdCheck("post_reset", 18'h0, 18'h3, 4'h0, 4'h1, 4'h1, 10);
    applyStimulus(18'h0, 4'hF);
    holdCheck("post_reset_clr", 18'h3, 18'h0, 4'h1, 4'h0, 4'h0, 10);

    // All 22 channels change together
    applyStimulus(18'h3FFFF, 4'h0);
    holdCheck("all_on", 18'h0, 18'h3FFFF, 4'h0, 4'hF, 4'hF, 10);
    applyStimulus(18'h00000, 4'hF);
    holdCheck("all_off", 18'h3FFFF, 18'h0, 4'hF, 4'h0, 4'h0, 10);

    repeat (3) @(posedge clk);
    #2;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain: pending=%0d expected=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
